// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_CLR   = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADC   = 4'b0011;
  localparam logic [3:0] OP_ADDM1 = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_DEC   = 4'b0110;
  localparam logic [3:0] OP_SET   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_XNOR  = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_SHR   = 4'b1101;
  localparam logic [3:0] OP_NOT   = 4'b1110;
  localparam logic [3:0] OP_MUL   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic                 done_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   step_sum;

  // lo_q starts as the multiplier and is shifted out as product bits shift in
  assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q <= a_i;
        hi_q    <= '0;
        lo_q    <= b_i;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        {hi_q, lo_q} <= {step_sum, lo_q[WIDTH-1:1]};
        cnt_q        <= cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign prod_o = {hi_q, lo_q};
  assign done_o = done_q;

endmodule

// File: rtl/alu_seq_acc.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, flags, accumulator operand and iterative multiply.
module alu_seq_acc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]   ONE_U    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH+1:0] ONE_S    = {{(WIDTH+1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    res_q;
  logic [WIDTH-1:0]    res_hi_q;
  logic [FLAG_W-1:0]   flags_q;
  logic                err_q;
  logic [WIDTH-1:0]    acc_q;

  logic [WIDTH-1:0]    a_op;
  logic [WIDTH:0]      za, zb, u_sum;
  logic [WIDTH+1:0]    sx_a, sx_b, s_sum;
  logic                arith, c_d, v_d, err_d;
  logic [WIDTH-1:0]    res_d;
  logic [FLAG_W-1:0]   flags_d;
  logic                accept, is_mul, mul_done;
  logic [2*WIDTH-1:0]  mul_prod;

  assign a_op     = use_acc ? acc_q : a_in;
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) && MUL_EN;

  // Carry comes from a zero-extended sum, overflow from a two-bit sign-extended one
  always_comb begin
    za      = {1'b0, a_op};
    zb      = {1'b0, b_in};
    sx_a    = {{2{a_op[WIDTH-1]}}, a_op};
    sx_b    = {{2{b_in[WIDTH-1]}}, b_in};
    u_sum   = '0;
    s_sum   = '0;
    arith   = 1'b0;
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    err_d   = 1'b0;
    flags_d = '0;
    case (op)
      OP_CLR:   res_d = '0;
      OP_INC:   begin arith = 1'b1; u_sum = za + ONE_U;      s_sum = sx_a + ONE_S;        end
      OP_ADD:   begin arith = 1'b1; u_sum = za + zb;         s_sum = sx_a + sx_b;         end
      OP_ADC:   begin arith = 1'b1; u_sum = za + zb + ONE_U; s_sum = sx_a + sx_b + ONE_S; end
      OP_ADDM1: begin arith = 1'b1; u_sum = za + zb - ONE_U; s_sum = sx_a + sx_b - ONE_S; end
      OP_SUB:   begin arith = 1'b1; u_sum = za - zb;         s_sum = sx_a - sx_b;         end
      OP_DEC:   begin arith = 1'b1; u_sum = za - ONE_U;      s_sum = sx_a - ONE_S;        end
      OP_SET:   begin res_d = '1; c_d = 1'b1; end
      OP_OR:    res_d = a_op | b_in;
      OP_AND:   res_d = a_op & b_in;
      OP_XNOR:  res_d = ~(a_op ^ b_in);
      OP_SHL:   begin res_d = {a_op[WIDTH-2:0], 1'b0}; c_d = a_op[WIDTH-1]; end
      OP_XOR:   res_d = a_op ^ b_in;
      OP_SHR:   begin res_d = {1'b0, a_op[WIDTH-1:1]}; c_d = a_op[0]; end
      OP_NOT:   res_d = ~a_op;
      OP_MUL:   err_d = 1'b1;
      default:  res_d = '0;
    endcase
    if (arith) begin
      res_d = u_sum[WIDTH-1:0];
      c_d   = u_sum[WIDTH];
      v_d   = (s_sum[WIDTH+1:WIDTH-1] != 3'b000) && (s_sum[WIDTH+1:WIDTH-1] != 3'b111);
    end
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_Z] = !err_d && (res_d == '0);
    flags_d[FLAG_N] = !err_d && res_d[WIDTH-1];
    flags_d[FLAG_V] = v_d;
  end

  if (MUL_EN) begin : g_mul
    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (accept && is_mul),
      .a_i     (a_op),
      .b_i     (b_in),
      .prod_o  (mul_prod),
      .done_o  (mul_done)
    );
  end else begin : g_nomul
    assign mul_prod = '0;
    assign mul_done = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_BUSY;
              cnt_q   <= '0;
            end else begin
              res_q       <= res_d;
              res_hi_q    <= '0;
              flags_q     <= flags_d;
              err_q       <= err_d;
              out_valid_q <= 1'b1;
              if (!err_d) acc_q <= res_d;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (mul_done) begin
            res_q           <= mul_prod[WIDTH-1:0];
            res_hi_q        <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_q[FLAG_Z] <= (mul_prod[WIDTH-1:0] == '0);
            flags_q[FLAG_N] <= mul_prod[WIDTH-1];
            flags_q[FLAG_V] <= 1'b0;
            err_q           <= 1'b0;
            out_valid_q     <= 1'b1;
            acc_q           <= mul_prod[WIDTH-1:0];
            state_q         <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];
  assign flag_v    = flags_q[FLAG_V];
  assign err       = err_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_seq_acc.sv
// Scoreboard bench for alu_seq_acc: directed corner cases plus randomized traffic against an arithmetic model.
module tb_alu_seq_acc;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic         err;
    logic [W-1:0] acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic         use_acc = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, result_hi, acc;
  logic         flag_c, flag_z, flag_n, flag_v, err;

  logic         e_in_valid = 1'b0;
  logic         e_in_ready;
  logic [3:0]   e_op = 4'h0;
  logic         e_use_acc = 1'b0;
  logic [W-1:0] e_a = '0;
  logic [W-1:0] e_b = '0;
  logic         e_out_valid;
  logic         e_out_ready = 1'b1;
  logic [W-1:0] e_result, e_result_hi, e_acc;
  logic         e_flag_c, e_flag_z, e_flag_n, e_flag_v, e_err;

  int           n_vec = 0;
  int           n_bad = 0;
  int           ready_mode = 1;   // 0 random, 1 high, 2 low
  logic [W-1:0] m_acc = '0;
  exp_t         sb[$];
  exp_t         mon_act;

  alu_seq_acc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .use_acc(use_acc),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .err(err), .acc(acc)
  );

  alu_seq_acc #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .op(e_op), .use_acc(e_use_acc),
    .a_in(e_a), .b_in(e_b), .out_valid(e_out_valid), .out_ready(e_out_ready), .result(e_result),
    .result_hi(e_result_hi), .flag_c(e_flag_c), .flag_z(e_flag_z), .flag_n(e_flag_n), .flag_v(e_flag_v),
    .err(e_err), .acc(e_acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on the opcode table
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit mul_en, input logic [W-1:0] acc_before);
    exp_t e;
    int   ua, ub, sa, sbv, full, sfull, prod;
    bit   arith;
    e = '0;
    arith = 1'b0;
    full = 0;
    sfull = 0;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sbv = (ub >= 128) ? ub - 256 : ub;
    case (o)
      4'h0: begin e.res = '0; e.c = 1'b0; end
      4'h1: begin arith = 1'b1; full = ua + 1;      sfull = sa + 1;       end
      4'h2: begin arith = 1'b1; full = ua + ub;     sfull = sa + sbv;     end
      4'h3: begin arith = 1'b1; full = ua + ub + 1; sfull = sa + sbv + 1; end
      4'h4: begin arith = 1'b1; full = ua + ub - 1; sfull = sa + sbv - 1; end
      4'h5: begin arith = 1'b1; full = ua - ub;     sfull = sa - sbv;     end
      4'h6: begin arith = 1'b1; full = ua - 1;      sfull = sa - 1;       end
      4'h7: begin e.res = '1; e.c = 1'b1; end
      4'h8: e.res = a | b;
      4'h9: e.res = a & b;
      4'hA: e.res = ~(a ^ b);
      4'hB: begin e.res = W'(ua * 2); e.c = (ua >= 128); end
      4'hC: e.res = a ^ b;
      4'hD: begin e.res = W'(ua / 2); e.c = (ua % 2 == 1); end
      4'hE: e.res = ~a;
      default: begin
        if (mul_en) begin
          prod = ua * ub;
          e.res = W'(prod);
          e.hi = W'(prod / 256);
          e.c = (prod >= 256);
        end else begin
          e.err = 1'b1;
        end
      end
    endcase
    if (arith) begin
      e.res = W'(full);
      e.c = ((full & 256) != 0);
      e.v = (sfull > 127) || (sfull < -128);
    end
    e.z = !e.err && (e.res == '0);
    e.n = !e.err && (e.res >= 8'h80);
    e.acc = e.err ? acc_before : e.res;
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ua, input bit track, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    op = o; a_in = a; b_in = b; use_acc = ua; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waited);
      in_valid = 1'b0;
      return;
    end
    e = model(o, ua ? m_acc : a, b, 1'b1, m_acc);
    @(posedge clk);
    if (track) begin
      sb.push_back(e);
      m_acc = e.acc;
    end
    #1 in_valid = 1'b0;
  endtask

  // Monitor: drives out_ready, compares presented results against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      #1;
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: out_valid=1 with nothing pending, expected 0");
        end else begin
          mon_act = {result, result_hi, flag_c, flag_z, flag_n, flag_v, err, acc};
          if (out_ready) begin
            check("result", 64'(mon_act), 64'(sb[0]));
            void'(sb.pop_front());
          end else begin
            check("hold", 64'(mon_act), 64'(sb[0]));
            check("in_ready_hold", 64'(in_ready), 64'(0));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int n;
    logic [3:0] o;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, result, result_hi, flag_c, flag_z, flag_n, flag_v, err, acc}), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_nomul", 64'({e_out_valid, e_err, e_result, e_acc, e_in_ready}), 64'(0));
    rst = 1'b0;
    m_acc = '0;

    // reset in the middle of a multiply
    issue(4'hF, 8'd7, 8'd9, 1'b0, 1'b0, wt);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_acc", 64'(acc), 64'(0));
    n = 0;
    repeat (W + 4) begin
      @(negedge clk);
      #1;
      if (out_valid) n++;
    end
    check("abort_no_output", 64'(n), 64'(0));
    m_acc = '0;

    // MUL_EN=0 instance: err result, acc preserved, err clears on next op
    @(negedge clk);
    e_op = 4'h2; e_a = 8'd5; e_b = 8'd6; e_in_valid = 1'b1;
    #1 check("e_in_ready", 64'(e_in_ready), 64'(1));
    @(posedge clk);
    #1 e_in_valid = 1'b0;
    check("e_add", 64'({e_out_valid, e_err, e_result}), 64'({1'b1, 1'b0, 8'd11}));
    @(negedge clk);
    e_op = 4'hF; e_a = 8'd3; e_b = 8'd5; e_in_valid = 1'b1;
    @(posedge clk);
    #1 e_in_valid = 1'b0;
    check("e_mul_err", 64'({e_out_valid, e_err, e_result, e_result_hi, e_flag_c, e_flag_z, e_flag_n, e_flag_v}),
          64'({2'b11, 20'h0}));
    check("e_acc_keep", 64'(e_acc), 64'(11));
    @(negedge clk);
    e_op = 4'h1; e_use_acc = 1'b1; e_in_valid = 1'b1;
    @(posedge clk);
    #1 e_in_valid = 1'b0;
    check("e_err_clear", 64'({e_out_valid, e_err, e_result, e_acc}), 64'({2'b10, 8'd12, 8'd12}));

    // directed arithmetic corners
    ready_mode = 1;
    issue(4'h2, 8'hFF, 8'h01, 1'b0, 1'b1, wt);
    check("latency_1", 64'(out_valid), 64'(1));
    issue(4'h2, 8'h7F, 8'h01, 1'b0, 1'b1, wt);
    issue(4'h5, 8'h03, 8'h05, 1'b0, 1'b1, wt);
    issue(4'h5, 8'h10, 8'h10, 1'b0, 1'b1, wt);
    issue(4'h1, 8'hFF, 8'h00, 1'b0, 1'b1, wt);
    issue(4'h6, 8'h00, 8'h00, 1'b0, 1'b1, wt);
    issue(4'h7, 8'h12, 8'h34, 1'b0, 1'b1, wt);
    issue(4'h4, 8'h80, 8'h00, 1'b0, 1'b1, wt);

    // full-scale multiply latency and busy window
    issue(4'hF, 8'hFF, 8'hFF, 1'b0, 1'b1, wt);
    n = 0;
    while (!out_valid && n < 40) begin
      check("mul_busy_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_latency", 64'(n), 64'(9));
    check("mul_product", 64'({result_hi, result, flag_c}), 64'({16'hFE01, 1'b1}));

    // back-pressure hold then release
    issue(4'h8, 8'hA5, 8'h0F, 1'b0, 1'b1, wt);
    ready_mode = 2;
    repeat (4) @(negedge clk);
    #2 ready_mode = 1;
    issue(4'hC, 8'h3C, 8'hFF, 1'b0, 1'b1, wt);
    check("release_accept", 64'(wt), 64'(0));

    // accumulator chain at full rate
    issue(4'h0, 8'h55, 8'h00, 1'b1, 1'b1, wt);
    for (int i = 0; i < 3; i++) begin
      issue(4'h1, 8'hAA, 8'h00, 1'b1, 1'b1, wt);
      check("chain_rate", 64'(wt), 64'(0));
    end
    check("acc_chain", 64'(acc), 64'(3));

    // randomized traffic with random back-pressure
    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      issue(o, W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0), 1'b1, wt);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    ready_mode = 1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
